// File: rtl/risco5_uart_pkg.sv
// risco5_uart_pkg
// Shared definitions for the Risco-5 UART blocks: receiver FSM state
// encoding, the data-bit width and the baud divider helper used by both
// the transmitter and the receiver.
package risco5_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_BITS = 8;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int clks_per_bit(input int clk_freq, input int bit_rate);
        return clk_freq / bit_rate;
    endfunction

endpackage

// File: rtl/risco5_sync_fifo.sv
// risco5_sync_fifo
// Single-clock FIFO used as receive storage when UART_RX_FIFO_EN is defined.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// A push while full is accepted only when a pop happens in the same cycle.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, push_data - write request and data
//   pop             - read request (ignored while empty)
//   pop_data        - oldest entry (valid while !empty)
//   empty, full     - occupancy flags
module risco5_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push_s = push && (!full || do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer and storage update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/risco5_uart_rx.sv
// risco5_uart_rx
// 8N1 UART receiver for the Risco-5 core. Recovers frames from the rx pad,
// samples each bit mid-period and hands bytes to the peripheral bus over a
// valid/ready handshake.
// Build option: define UART_RX_FIFO_EN to replace the single holding
// register with a FIFO_DEPTH-entry FIFO (risco5_sync_fifo).
// Ports:
//   clk, rst     - system clock, asynchronous active-high reset
//   rx           - serial input (asynchronous, idle high)
//   rd_data      - oldest received byte
//   rd_valid     - rd_data holds a byte; pop when rd_valid && rd_ready
//   rd_ready     - consumer accepts the byte
//   frame_error  - one-cycle pulse, stop bit sampled low
//   overrun      - one-cycle pulse, good byte dropped because storage full
//   busy         - receiver FSM is not idle
module risco5_uart_rx
    import risco5_uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BIT_RATE   = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    // CLKS_PER_BIT must be at least 4 for the half-bit start alignment.
    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BIT_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic                      rx_meta_r;
    logic                      rx_s_r;
    uart_rx_state_t            state_r, state_next;
    logic [CNT_W-1:0]          baud_cnt_r, baud_cnt_next;
    logic [2:0]                bit_idx_r, bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift_r, shift_next;
    logic                      push_s;
    logic                      frame_err_s;
    logic                      overrun_s;
    logic                      pop_s;
    logic                      busy_r;
    logic                      frame_error_r;
    logic                      overrun_r;

    assign busy        = busy_r;
    assign frame_error = frame_error_r;
    assign overrun     = overrun_r;
    assign pop_s       = rd_valid && rd_ready;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
        end
    end

    // Receiver FSM next-state and datapath decode.
    always_comb begin
        state_next    = state_r;
        baud_cnt_next = baud_cnt_r;
        bit_idx_next  = bit_idx_r;
        shift_next    = shift_r;
        push_s        = 1'b0;
        frame_err_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (!rx_s_r) begin
                    baud_cnt_next = CNT_HALF;
                    state_next    = START;
                end else begin
                    state_next = IDLE;
                end
            end
            START: begin
                if (baud_cnt_r == CNT_ZERO) begin
                    if (!rx_s_r) begin
                        baud_cnt_next = CNT_FULL;
                        bit_idx_next  = 3'd0;
                        state_next    = DATA;
                    end else begin
                        // Glitch shorter than half a bit: false start.
                        state_next = IDLE;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_r - CNT_ONE;
                end
            end
            DATA: begin
                if (baud_cnt_r == CNT_ZERO) begin
                    shift_next    = {rx_s_r, shift_r[UART_DATA_BITS-1:1]};
                    baud_cnt_next = CNT_FULL;
                    if (bit_idx_r == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_r + 3'd1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_r - CNT_ONE;
                end
            end
            STOP: begin
                if (baud_cnt_r == CNT_ZERO) begin
                    // Leave at mid stop bit so a following start edge is not missed.
                    state_next = IDLE;
                    if (rx_s_r) begin
                        push_s = 1'b1;
                    end else begin
                        frame_err_s = 1'b1;
                    end
                end else begin
                    baud_cnt_next = baud_cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Receiver FSM and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= {UART_DATA_BITS{1'b0}};
        end else begin
            state_r    <= state_next;
            baud_cnt_r <= baud_cnt_next;
            bit_idx_r  <= bit_idx_next;
            shift_r    <= shift_next;
        end
    end

    // Registered status pulses and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_r        <= 1'b0;
            frame_error_r <= 1'b0;
            overrun_r     <= 1'b0;
        end else begin
            busy_r        <= (state_next != IDLE);
            frame_error_r <= frame_err_s;
            overrun_r     <= overrun_s;
        end
    end

`ifdef UART_RX_FIFO_EN
    logic                      fifo_empty_s;
    logic                      fifo_full_s;
    logic [UART_DATA_BITS-1:0] fifo_data_s;

    risco5_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (shift_r),
        .pop       (rd_ready),
        .pop_data  (fifo_data_s),
        .empty     (fifo_empty_s),
        .full      (fifo_full_s)
    );

    assign rd_valid  = !fifo_empty_s;
    assign rd_data   = fifo_data_s;
    assign overrun_s = push_s && fifo_full_s && !pop_s;
`else
    logic                      hold_valid_r;
    logic [UART_DATA_BITS-1:0] hold_data_r;

    assign rd_valid  = hold_valid_r;
    assign rd_data   = hold_data_r;
    assign overrun_s = push_s && hold_valid_r && !pop_s;

    // Single holding register; a same-cycle pop frees the slot for the push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_r <= 1'b0;
            hold_data_r  <= {UART_DATA_BITS{1'b0}};
        end else if (push_s && (!hold_valid_r || pop_s)) begin
            hold_valid_r <= 1'b1;
            hold_data_r  <= shift_r;
        end else if (pop_s) begin
            hold_valid_r <= 1'b0;
        end else begin
            hold_valid_r <= hold_valid_r;
        end
    end
`endif

endmodule

// File: tb/tb_risco5_uart_rx.sv
// tb_risco5_uart_rx
// Directed bench for risco5_uart_rx at CLKS_PER_BIT = 16
// (CLK_FREQ = 1600, BIT_RATE = 100).
module tb_risco5_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       frame_error;
    logic       overrun;
    logic       busy;

    int errors = 0;
    int checks = 0;

    // Event counters sampled at the falling edge, away from the active edge.
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    int         rv_cnt = 0;
    logic [7:0] pop_q[$];

    risco5_uart_rx #(
        .CLK_FREQ   (1600),
        .BIT_RATE   (100),
        .FIFO_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_error) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rd_valid) rv_cnt++;
        if (rd_valid && rd_ready) pop_q.push_back(rd_data);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame starting now (just after an edge); lasts 160 cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(16);
        end
        rx = stop_bit;
        tick(16);
        rx = 1'b1;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({rd_data, rd_valid, frame_error, overrun, busy} !== 12'h000) begin
            errors++;
            $display("FAIL %s: got data=%h valid=%b fe=%b ov=%b busy=%b expected all zero",
                     tag, rd_data, rd_valid, frame_error, overrun, busy);
        end
    endtask

    task automatic test_reset;
        tick(3);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        tick(5);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_basic_rx;
        logic stable;
        stable = 1'b1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                tick(154);
                checks++;
                if (rd_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL basic_c154: got valid=%b busy=%b expected valid=0 busy=1", rd_valid, busy);
                end
                tick(1);
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_c155: got valid=%b data=%h busy=%b expected 1 a5 0", rd_valid, rd_data, busy);
                end
            end
        join
        for (int i = 0; i < 50; i++) begin
            if (rd_valid !== 1'b1 || rd_data !== 8'hA5) stable = 1'b0;
            tick(1);
        end
        checks++;
        if (stable !== 1'b1) begin
            errors++;
            $display("FAIL basic_stable: got stable=%b expected 1", stable);
        end
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop: got valid=%b expected 0", rd_valid);
        end
    endtask

    task automatic test_false_start;
        int fe0, rv0;
        fe0 = fe_cnt;
        rv0 = rv_cnt;
        rx = 1'b0;
        tick(4);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL false_busy_on: got %b expected 1", busy);
        end
        tick(2);
        rx = 1'b1;
        tick(6);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL false_busy_off: got %b expected 0", busy);
        end
        tick(30);
        checks++;
        if (fe_cnt - fe0 !== 0 || rv_cnt - rv0 !== 0) begin
            errors++;
            $display("FAIL false_outputs: got fe=%0d valid_cycles=%0d expected 0 0", fe_cnt - fe0, rv_cnt - rv0);
        end
    endtask

    task automatic test_frame_error;
        int fe0, rv0;
        fe0 = fe_cnt;
        rv0 = rv_cnt;
        send_frame(8'h3C, 1'b0);
        tick(30);
        checks++;
        if (fe_cnt - fe0 !== 1 || rv_cnt - rv0 !== 0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL ferr_pulse: got fe=%0d valid_cycles=%0d valid=%b expected 1 0 0",
                     fe_cnt - fe0, rv_cnt - rv0, rd_valid);
        end
        send_frame(8'h01, 1'b1);
        tick(5);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h01) begin
            errors++;
            $display("FAIL ferr_next: got valid=%b data=%h expected 1 01", rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(5);
    endtask

    task automatic test_overrun;
        int ov0;
        ov0 = ov_cnt;
`ifdef UART_RX_FIFO_EN
        for (int b = 0; b < 9; b++) send_frame(8'(b), 1'b1);
        tick(5);
        checks++;
        if (ov_cnt - ov0 !== 1) begin
            errors++;
            $display("FAIL ovr_count: got %0d expected 1", ov_cnt - ov0);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(b)) begin
                errors++;
                $display("FAIL ovr_order: got valid=%b data=%h expected 1 %h", rd_valid, rd_data, 8'(b));
            end
            rd_ready = 1'b1;
            tick(1);
            rd_ready = 1'b0;
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovr_empty: got valid=%b expected 0", rd_valid);
        end
        // Leave one byte held so the reset test can see storage cleared.
        send_frame(8'h77, 1'b1);
        tick(5);
`else
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        tick(5);
        checks++;
        if (ov_cnt - ov0 !== 1 || rd_valid !== 1'b1 || rd_data !== 8'h11) begin
            errors++;
            $display("FAIL ovr_hold: got ov=%0d valid=%b data=%h expected 1 1 11", ov_cnt - ov0, rd_valid, rd_data);
        end
`endif
    endtask

    task automatic test_reset_mid_frame;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(80);
                checks++;
                if (busy !== 1'b1 || rd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rst_pre: got busy=%b valid=%b expected 1 1", busy, rd_valid);
                end
                rst = 1'b1;
                #1;
                check_idle_outputs("rst_async");
                tick(3);
                rst = 1'b0;
            end
        join
        tick(20);
        check_idle_outputs("rst_frame_lost");
        send_frame(8'h5A, 1'b1);
        tick(5);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
            errors++;
            $display("FAIL rst_recover: got valid=%b data=%h expected 1 5a", rd_valid, rd_data);
        end
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
        tick(5);
    endtask

    task automatic test_back_to_back;
        int ov0, rv0, q0;
        logic [7:0] exp_bytes [3];
        exp_bytes[0] = 8'h55;
        exp_bytes[1] = 8'hAA;
        exp_bytes[2] = 8'h0F;
        ov0 = ov_cnt;
        rv0 = rv_cnt;
        q0  = pop_q.size();
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(exp_bytes[i], 1'b1);
        tick(5);
        rd_ready = 1'b0;
        checks++;
        if (rv_cnt - rv0 !== 3 || ov_cnt - ov0 !== 0 || pop_q.size() - q0 !== 3) begin
            errors++;
            $display("FAIL b2b_counts: got valid_cycles=%0d ov=%0d pops=%0d expected 3 0 3",
                     rv_cnt - rv0, ov_cnt - ov0, pop_q.size() - q0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (pop_q[q0 + i] !== exp_bytes[i]) begin
                    errors++;
                    $display("FAIL b2b_data: got %h expected %h", pop_q[q0 + i], exp_bytes[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_rx();
        test_false_start();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/risco5_uart_rx.md
# risco5_uart_rx

Asynchronous serial receiver that recovers 8N1 frames arriving on a Tiny Tapeout input pin (`ui_in` bit) and presents received bytes to the Risco-5 core's peripheral bus through a valid/ready handshake. It is the receive end of the core's UART link: the core already transmits, and this block lets a host or the cocotb bench send bytes back into the chip. It sits between the pad-side `ui_in` wiring in `tt_um_Risco_5` and the core's MMIO peripheral decode.

## Interface
Parameters:
- `CLK_FREQ`, 25_000_000: system clock frequency in Hz.
- `BIT_RATE`, 115200: serial bit rate in baud. `CLKS_PER_BIT = CLK_FREQ / BIT_RATE`, integer division, must be at least 4.
- `FIFO_DEPTH`, 8: receive FIFO depth, a power of two. Used only when `UART_RX_FIFO_EN` is defined.

Ports:
- `clk`, in, 1: system clock. This is the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `rx`, in, 1: serial input. Asynchronous to `clk`. Idle level is high.
- `rd_data`, out, 8: oldest received byte.
- `rd_valid`, out, 1: `rd_data` holds a valid byte.
- `rd_ready`, in, 1: consumer accepts the byte. A pop occurs in a cycle where `rd_valid && rd_ready`.
- `frame_error`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a good byte is dropped because storage is full.
- `busy`, out, 1: high while the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer with reset value 1. All logic below uses the synchronized signal `rx_s`.
- FSM states: IDLE, START, DATA, STOP.
  - **IDLE:** on `rx_s == 0`, load bit counter `baud_cnt = CLKS_PER_BIT/2 - 1` and go to START.
  - **START:** when `baud_cnt` reaches 0, sample `rx_s`.
    - Sample low: reload `baud_cnt = CLKS_PER_BIT - 1`, set `bit_idx = 0`, go to DATA.
    - Sample high: this is a false start. Return to IDLE with no outputs.
  - **DATA:** at each `baud_cnt` reaching 0, shift `rx_s` into the shift register, LSB first, and reload `baud_cnt`. After `bit_idx == 7`, go to STOP.
  - **STOP:** at `baud_cnt` reaching 0, sample `rx_s`.
    - Sample high: push the byte.
    - Sample low: pulse `frame_error` and discard the byte.
    - In both cases return to IDLE that same cycle. The FSM does not wait for the end of the stop bit, so back-to-back frames are tolerated.
- Storage without the FIFO is a single holding register.
  - A push while `rd_valid == 0` loads it.
  - A push while `rd_valid == 1` and no pop that cycle drops the new byte and pulses `overrun`.
  - A push and a pop in the same cycle: the pop completes and the new byte loads, with no overrun.
- `rd_data` must stay stable while `rd_valid && !rd_ready`.
- Reset mid-frame: the FSM returns to IDLE, storage empties, and all pulses clear. A frame already in progress when `rst` deasserts is lost. The receiver resynchronizes on the next falling edge seen in IDLE.

## Timing
- Reset values:
  - `rd_data = 8'h00`
  - `rd_valid = 0`
  - `frame_error = 0`
  - `overrun = 0`
  - `busy = 0`
  - synchronizer flops = 1
- Latency: with the `rx` falling edge at cycle 0, `rx_s` falls at cycle 2.
  - The start sample is taken at cycle `2 + CLKS_PER_BIT/2`.
  - Data bit n is sampled `(n+1)·CLKS_PER_BIT` cycles later.
  - The stop bit is sampled `9·CLKS_PER_BIT` cycles after the start sample.
  - `rd_valid` is registered and rises on the cycle after the stop sample.
  - Example: at `CLKS_PER_BIT = 16`, stop sample at cycle 154 and `rd_valid` high at cycle 155.
- `frame_error` and `overrun` are registered. Each asserts for exactly one cycle, the cycle after the stop sample.
- `busy` rises on the cycle after IDLE detects `rx_s == 0`. It falls on the cycle after the stop sample.

## Configuration
- `UART_RX_FIFO_EN` defined: storage is a `FIFO_DEPTH`-entry FIFO.
  - `rd_valid` means the FIFO is not empty.
  - `overrun` pulses only when the FIFO is full and there is no pop in the same cycle.
  - A simultaneous push and pop on a full FIFO succeeds.
  - Pointers are `$clog2(FIFO_DEPTH)+1` bits with a wrap bit for full/empty detection.
- `UART_RX_FIFO_EN` undefined: storage is the single holding register described under Operation. `FIFO_DEPTH` is ignored.

## Structure
- Package `risco5_uart_pkg` holds:
  - the FSM state enum `uart_rx_state_t` (IDLE, START, DATA, STOP)
  - `UART_DATA_BITS = 8`
  - a `clks_per_bit` constant function, shared with the existing transmitter
- Sub-module `risco5_sync_fifo` (clk, rst, push, push_data, pop, pop_data, empty, full) is instantiated only under `UART_RX_FIFO_EN`.

## Test plan
All scenarios use `CLK_FREQ = 1600`, `BIT_RATE = 100`, giving `CLKS_PER_BIT = 16`.
1. Send 8'hA5 with 8N1 framing and `rd_ready = 0` -> `rd_valid` rises 155 cycles after the falling edge with `rd_data = 8'hA5`. Data stays stable for 50 cycles, then pop with `rd_ready = 1` -> `rd_valid = 0` on the next cycle.
2. Drop `rx` low for 6 cycles, then return high -> false start: no `rd_valid`, no `frame_error`, and `busy` deasserted by cycle 12.
3. Send 8'h3C with the stop bit driven low -> exactly one `frame_error` pulse, `rd_valid` stays 0, and the next frame 8'h01 is received correctly.
4. Without the FIFO, send 8'h11 then 8'h22 back-to-back with `rd_ready = 0` -> `rd_data = 8'h11` retained and one `overrun` pulse. With `UART_RX_FIFO_EN`, send 9 bytes 8'h00..8'h08 -> the first 8 pop in order and one `overrun` pulse occurs, for 8'h08.
5. Assert `rst` for 3 cycles midway through DATA of 8'hFF -> all outputs return to their reset values immediately. A following frame 8'h5A is received correctly.
6. Hold `rd_ready = 1` continuously and stream 8'h55, 8'hAA, 8'h0F back-to-back -> three single-cycle `rd_valid` pulses carrying the bytes in order, with no `overrun`.
